// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// major opcodes and the datapath mux/ALU select codes.
package ctrl_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADR   = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JALR      = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_LUI       = 4'd12;
    localparam logic [3:0] S_AUIPC     = 4'd13;
    localparam logic [3:0] S_ILLEGAL   = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {A_PC = 2'b00, A_OLD_PC = 2'b01, A_RS1 = 2'b10} alu_src_a_e;
    typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_src_b_e;
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_BRANCH = 2'b01, ALU_FUNCT = 2'b10, ALU_PASS_B = 2'b11
    } alu_op_e;
    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
        IMM_U = 3'b011, IMM_J = 3'b100, IMM_SHIFT = 3'b101
    } imm_src_e;
    typedef enum logic [1:0] {
        RES_ALU_OUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10
    } result_src_e;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select, decoded purely from the instruction register
// so the immediate generator is valid in every FSM state.
module imm_src_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct_3_i,
    output logic [2:0] imm_src_o
);

    always_comb begin
        case (opcode_i)
            // SLLI/SRLI/SRAI carry a shamt plus funct7 in the immediate field
            OP_IMM:           imm_src_o = (funct_3_i == 3'b001 || funct_3_i == 3'b101)
                                          ? IMM_SHIFT : IMM_I;
            OP_STORE:         imm_src_o = IMM_S;
            OP_BRANCH:        imm_src_o = IMM_B;
            OP_LUI, OP_AUIPC: imm_src_o = IMM_U;
            OP_JAL:           imm_src_o = IMM_J;
            default:          imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU, register file,
// IR and unified memory port, stalling on the mem_ready_i handshake.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct_3_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    output logic       pc_wr_en_o,
    output logic       ir_wr_en_o,
    output logic       adr_src_o,
    output logic       mem_req_o,
    output logic       mem_wr_en_o,
    output logic       reg_wr_en_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [2:0] imm_src_o,
    output logic [1:0] result_src_o,
    output logic       illegal_instr_o
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [2:0] imm_dec;

    imm_src_decoder u_imm_src_decoder (
        .opcode_i  (opcode_i),
        .funct_3_i (funct_3_i),
        .imm_src_o (imm_dec)
    );

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= state_next;
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next      = state;
        pc_wr_en_o      = 1'b0;
        ir_wr_en_o      = 1'b0;
        adr_src_o       = 1'b0;
        mem_req_o       = 1'b0;
        mem_wr_en_o     = 1'b0;
        reg_wr_en_o     = 1'b0;
        alu_src_a_o     = A_PC;
        alu_src_b_o     = B_RS2;
        alu_op_o        = ALU_ADD;
        result_src_o    = RES_ALU_OUT;
        illegal_instr_o = 1'b0;
        imm_src_o       = rst_i ? IMM_I : imm_dec;

        // Reset gates the decode so an in-flight access or write-back is dropped
        // in the same cycle, not one cycle later.
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    mem_req_o    = 1'b1;
                    alu_src_b_o  = B_FOUR;
                    result_src_o = RES_ALU;
                    if (mem_ready_i) begin
                        ir_wr_en_o = 1'b1;
                        pc_wr_en_o = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a_o = A_OLD_PC;
                    alu_src_b_o = B_IMM;
                    case (opcode_i)
                        OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                        OP_REG:            state_next = S_EXEC_R;
                        OP_IMM:            state_next = S_EXEC_I;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JUMP;
                        OP_JALR:           state_next = S_JALR;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_ILLEGAL;
                    endcase
                end
                S_MEM_ADR: begin
                    alu_src_a_o = A_RS1;
                    alu_src_b_o = B_IMM;
                    state_next  = (opcode_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                    if (mem_ready_i) state_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    result_src_o = RES_MEM;
                    reg_wr_en_o  = 1'b1;
                    state_next   = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req_o   = 1'b1;
                    mem_wr_en_o = 1'b1;
                    adr_src_o   = 1'b1;
                    if (mem_ready_i) state_next = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a_o = A_RS1;
                    alu_op_o    = ALU_FUNCT;
                    state_next  = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a_o = A_RS1;
                    alu_src_b_o = B_IMM;
                    alu_op_o    = ALU_FUNCT;
                    state_next  = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_wr_en_o = 1'b1;
                    state_next  = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_o = A_RS1;
                    alu_op_o    = ALU_BRANCH;
                    pc_wr_en_o  = branch_taken_i;
                    state_next  = S_FETCH;
                end
                S_JALR: begin
                    alu_src_a_o = A_RS1;
                    alu_src_b_o = B_IMM;
                    state_next  = S_JUMP;
                end
                // PC takes the target held in ALUOut while the ALU forms the link address
                S_JUMP: begin
                    pc_wr_en_o  = 1'b1;
                    alu_src_a_o = A_OLD_PC;
                    alu_src_b_o = B_FOUR;
                    state_next  = S_ALU_WB;
                end
                S_LUI: begin
                    alu_src_b_o = B_IMM;
                    alu_op_o    = ALU_PASS_B;
                    state_next  = S_ALU_WB;
                end
                S_AUIPC: begin
                    alu_src_a_o = A_OLD_PC;
                    alu_src_b_o = B_IMM;
                    state_next  = S_ALU_WB;
                end
                S_ILLEGAL: begin
                    illegal_instr_o = 1'b1;
                    state_next      = S_FETCH;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded by a reference model
// into its per-cycle control vectors and compared cycle by cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       adr;
        logic       req;
        logic       wr;
        logic       reg_wr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [2:0] imm;
        logic [1:0] res;
        logic       ill;
    } ctrl_t;

    localparam logic [1:0] A_PC = 2'b00, A_OLD = 2'b01, A_RS1 = 2'b10;
    localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
    localparam logic [1:0] ADD = 2'b00, BRC = 2'b01, FNC = 2'b10, PASS = 2'b11;
    localparam logic [1:0] R_OUT = 2'b00, R_MEM = 2'b01, R_LIVE = 2'b10;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] opcode_i;
    logic [2:0] funct_3_i;
    logic       branch_taken_i;
    logic       mem_ready_i;
    logic       pc_wr_en_o, ir_wr_en_o, adr_src_o, mem_req_o, mem_wr_en_o, reg_wr_en_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic [2:0] imm_src_o;
    logic       illegal_instr_o;

    int checks = 0;
    int errors = 0;

    ctrl_t      exp_q[$];
    bit         rdy_q[$];
    logic [2:0] cur_imm;

    multicycle_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .opcode_i        (opcode_i),
        .funct_3_i       (funct_3_i),
        .branch_taken_i  (branch_taken_i),
        .mem_ready_i     (mem_ready_i),
        .pc_wr_en_o      (pc_wr_en_o),
        .ir_wr_en_o      (ir_wr_en_o),
        .adr_src_o       (adr_src_o),
        .mem_req_o       (mem_req_o),
        .mem_wr_en_o     (mem_wr_en_o),
        .reg_wr_en_o     (reg_wr_en_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .imm_src_o       (imm_src_o),
        .result_src_o    (result_src_o),
        .illegal_instr_o (illegal_instr_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [2:0] exp_imm(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0010011: return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic ctrl_t step(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] op, input logic [1:0] res);
        ctrl_t c = '0;
        c.a = a; c.b = b; c.op = op; c.res = res; c.imm = cur_imm;
        return c;
    endfunction

    task automatic push(input ctrl_t c, input bit r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into the control vector expected in each cycle,
    // plus the mem_ready value to drive in that cycle.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic tk,
                         input int fw, input int mw);
        ctrl_t c;
        exp_q.delete();
        rdy_q.delete();
        cur_imm = exp_imm(op, f3);
        for (int k = 0; k <= fw; k++) begin
            c = step(A_PC, B_FOUR, ADD, R_LIVE);
            c.req = 1'b1;
            c.ir_wr = (k == fw);
            c.pc_wr = (k == fw);
            push(c, k == fw);
        end
        push(step(A_OLD, B_IMM, ADD, R_OUT), rnd());
        case (op)
            7'b0000011, 7'b0100011: begin
                push(step(A_RS1, B_IMM, ADD, R_OUT), rnd());
                for (int k = 0; k <= mw; k++) begin
                    c = step(A_PC, B_RS2, ADD, R_OUT);
                    c.req = 1'b1;
                    c.adr = 1'b1;
                    c.wr  = (op == 7'b0100011);
                    push(c, k == mw);
                end
                if (op == 7'b0000011) begin
                    c = step(A_PC, B_RS2, ADD, R_MEM);
                    c.reg_wr = 1'b1;
                    push(c, rnd());
                end
            end
            7'b1100011: begin
                c = step(A_RS1, B_RS2, BRC, R_OUT);
                c.pc_wr = tk;
                push(c, rnd());
            end
            7'b0001111, 7'b1110011, 7'b0000000, 7'b1111111: begin
                c = step(A_PC, B_RS2, ADD, R_OUT);
                c.ill = 1'b1;
                push(c, rnd());
            end
            default: begin
                case (op)
                    7'b0110011: push(step(A_RS1, B_RS2, FNC, R_OUT), rnd());
                    7'b0010011: push(step(A_RS1, B_IMM, FNC, R_OUT), rnd());
                    7'b0110111: push(step(A_PC, B_IMM, PASS, R_OUT), rnd());
                    7'b0010111: push(step(A_OLD, B_IMM, ADD, R_OUT), rnd());
                    7'b1100111, 7'b1101111: begin
                        if (op == 7'b1100111) push(step(A_RS1, B_IMM, ADD, R_OUT), rnd());
                        c = step(A_OLD, B_FOUR, ADD, R_OUT);
                        c.pc_wr = 1'b1;
                        push(c, rnd());
                    end
                    default: begin
                        c = step(A_PC, B_RS2, ADD, R_OUT);
                        c.ill = 1'b1;
                        push(c, rnd());
                    end
                endcase
                if (exp_q[exp_q.size()-1].ill == 1'b0) begin
                    c = step(A_PC, B_RS2, ADD, R_OUT);
                    c.reg_wr = 1'b1;
                    push(c, rnd());
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input int idx, input ctrl_t e);
        ctrl_t o;
        o = {pc_wr_en_o, ir_wr_en_o, adr_src_o, mem_req_o, mem_wr_en_o, reg_wr_en_o,
             alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o, result_src_o, illegal_instr_o};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, idx, o, e);
        end
    endtask

    // Runs one instruction; abort_at >= 0 asserts reset in that cycle instead.
    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic tk, input int fw, input int mw, input int abort_at);
        build(op, f3, tk, fw, mw);
        opcode_i       = op;
        funct_3_i      = f3;
        branch_taken_i = tk;
        foreach (exp_q[i]) begin
            if (i == abort_at) begin
                rst_i       = 1'b1;
                mem_ready_i = 1'b1;
                @(negedge clk_i);
                check({tag, "_rst"}, i, '0);
                @(posedge clk_i); #1;
                rst_i = 1'b0;
                return;
            end
            mem_ready_i = rdy_q[i];
            @(negedge clk_i);
            check(tag, i, exp_q[i]);
            @(posedge clk_i); #1;
        end
    endtask

    logic [6:0] op_tbl[11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                               7'b1111111};

    initial begin
        rst_i          = 1'b1;
        opcode_i       = 7'b1101111;
        funct_3_i      = 3'd0;
        branch_taken_i = 1'b1;
        mem_ready_i    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("reset", k, '0);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        run("add",       7'b0110011, 3'd0, 1'b0, 0, 0, -1);
        run("lw",        7'b0000011, 3'd2, 1'b0, 0, 2, -1);
        run("beq_t",     7'b1100011, 3'd0, 1'b1, 0, 0, -1);
        run("beq_nt",    7'b1100011, 3'd0, 1'b0, 0, 0, -1);
        run("jalr",      7'b1100111, 3'd0, 1'b0, 0, 0, -1);
        run("jal",       7'b1101111, 3'd0, 1'b0, 1, 0, -1);
        run("fence_ill", 7'b0001111, 3'd0, 1'b0, 0, 0, -1);
        run("sw_abort",  7'b0100011, 3'd2, 1'b0, 0, 3, 4);
        run("slli",      7'b0010011, 3'd1, 1'b0, 0, 0, -1);
        run("srai",      7'b0010011, 3'd5, 1'b0, 0, 0, -1);
        run("lui",       7'b0110111, 3'd0, 1'b0, 0, 0, -1);
        run("auipc",     7'b0010111, 3'd0, 1'b0, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = op_tbl[$urandom_range(0, 10)];
            run("rand", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        run("final", 7'b0110011, 3'd0, 1'b0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
